plab5_mcore_net_to_mem_req_adapter: RTL and testbench
=====================================================

PLAB5_MCORE_NET_TO_MEM_REQ_ADAPTER -- requirements
Module: plab5_mcore_net_to_mem_req_adapter

Interface
REQ-001 SHALL have parameters: p_mem_opaque_nbits, default 8, mem opaque width (mo); p_mem_addr_nbits, default 32 (ma); p_mem_data_nbits, default 32 (md); p_net_opaque_nbits, default 4 (no); p_net_srcdest_nbits, default 3 (ns); p_secure_base, default 32'h8000, lowest address reserved for domain 1.
REQ-002 SHALL have one clock and a synchronous active-high reset.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 net_ctrl_val/net_ctrl_rdy  input/output  1/1  control-half handshake.
REQ-006 net_ctrl_msg  input  56  net control msg {dest[3], src[3], opaque[4], payload[46]}; payload = {domain[1], type[3], mem opaque[8], addr[32], len[2]}.
REQ-007 net_data_val/net_data_rdy  input/output  1/1  data-half handshake.
REQ-008 net_data_msg  input  32  write data word.
REQ-009 mem_req_val/mem_req_rdy  output/input  1/1  memory request handshake.
REQ-010 mem_req_msg  output  77  {type[3], opaque[8], addr[32], len[2], data[32]}.
REQ-011 deny_val/deny_rdy  output/input  1/1  access-denied notification handshake.
REQ-012 deny_opaque  output  8  mem opaque of the denied request.

Function
REQ-013 Control and data halves SHALL be captured independently into one-entry slots; a half transfers when val && rdy.
REQ-014 net_ctrl_rdy SHALL equal control slot empty; net_data_rdy SHALL equal data slot empty (no combinational val-to-rdy path).
REQ-015 Join FSM states: EMPTY, HAVE_CTRL, HAVE_DATA, JOINED; EMPTY->HAVE_CTRL/HAVE_DATA/JOINED on ctrl-only/data-only/both accepted; HAVE_x->JOINED when the other half is accepted; JOINED->EMPTY when the joined entry moves to the output stage.
REQ-016 Joined entry SHALL move to the output stage in the cycle the output stage is empty or draining (val && rdy); both slots freed in that cycle.
REQ-017 Output stage SHALL be a single register; mem_req_msg and deny_opaque SHALL stay stable while the respective val is high and rdy is low.
REQ-018 Latency: halves completing the join in cycle N SHALL produce mem_req_val (or deny_val) in cycle N+1; sustained throughput one request per cycle with rdy held high.
REQ-019 mem_req_msg SHALL carry type, mem opaque, addr, len from payload unchanged and data from the data half; net dest/src/opaque and domain bit SHALL be discarded.
REQ-020 Read requests (type 0) SHALL still require a data half; its value SHALL be passed through unmodified.
REQ-021 Exactly one of mem_req_val and deny_val SHALL be asserted per joined request; never both in one cycle.
REQ-022 Simultaneous arrival of both halves in EMPTY with output stage empty SHALL join in one cycle.
REQ-023 A second control half SHALL NOT be accepted before the first is joined and moved (no reordering between halves).

Reset
REQ-024 On reset: FSM=EMPTY, slots empty, output stage empty; mem_req_val=0, deny_val=0, net_ctrl_rdy=0 and net_data_rdy=0 during reset, mem_req_msg=0, deny_opaque=0.
REQ-025 Reset mid-operation SHALL discard captured halves and any undelivered output without issuing it.

Configuration
REQ-026 Macro PLAB5_MCORE_NET2MEM_DOMAIN_CHECK_EN: when defined, a request with domain=0 and addr >= p_secure_base SHALL go to the deny port instead of memory.
REQ-027 When not defined, all requests SHALL go to mem_req; deny_val SHALL be constant 0 and deny_opaque constant 0.

Verification
REQ-028 Ctrl (read, opaque 8'h21, addr 32'h100, domain 0) and data 32'h0 same cycle, mem_req_rdy=1 -> next cycle mem_req_val=1, type 0, opaque 8'h21, addr 32'h100.
REQ-029 Ctrl in cycle 2, data 32'hDEADBEEF in cycle 5 (write, addr 32'h200) -> net_ctrl_rdy=0 cycles 3-5, mem_req_val in cycle 6 with data 32'hDEADBEEF.
REQ-030 Back-to-back 8 joined requests, mem_req_rdy low for 3 cycles mid-stream -> msg held stable, all 8 delivered in order, no loss or duplication.
REQ-031 With macro: domain 0 write to 32'h9000, opaque 8'h42 -> deny_val=1, deny_opaque 8'h42, mem_req_val stays 0; domain 1 same address -> forwarded. Without macro: both forwarded.
REQ-032 Reset asserted with HAVE_CTRL and pending output -> after reset mem_req_val=0, deny_val=0, next ctrl+data pair yields exactly one request.

Source files
------------

// File: rtl/plab5_mcore_net_to_mem_req_adapter.sv
// Network-to-memory request adapter for the multicore lab.
// Joins the control half (header + payload) and the data half of a network
// message into a single memory request held in a one-entry output register.
// Optional feature macro: PLAB5_MCORE_NET2MEM_DOMAIN_CHECK_EN routes domain-0
// requests at or above p_secure_base to the deny port instead of memory.
module plab5_mcore_net_to_mem_req_adapter #(
  parameter int unsigned p_mem_opaque_nbits  = 8,
  parameter int unsigned p_mem_addr_nbits    = 32,
  parameter int unsigned p_mem_data_nbits    = 32,
  parameter int unsigned p_net_opaque_nbits  = 4,
  parameter int unsigned p_net_srcdest_nbits = 3,
  parameter int unsigned p_secure_base       = 32'h8000
) (
  input  logic                                      clk,
  input  logic                                      reset,

  input  logic                                      net_ctrl_val,
  output logic                                      net_ctrl_rdy,
  input  logic [2*p_net_srcdest_nbits+p_net_opaque_nbits
                +p_mem_addr_nbits+p_mem_opaque_nbits+5:0] net_ctrl_msg,

  input  logic                                      net_data_val,
  output logic                                      net_data_rdy,
  input  logic [p_mem_data_nbits-1:0]               net_data_msg,

  output logic                                      mem_req_val,
  input  logic                                      mem_req_rdy,
  output logic [p_mem_opaque_nbits+p_mem_addr_nbits
                +p_mem_data_nbits+4:0]              mem_req_msg,

  output logic                                      deny_val,
  input  logic                                      deny_rdy,
  output logic [p_mem_opaque_nbits-1:0]             deny_opaque
);

  localparam int unsigned MO = p_mem_opaque_nbits;
  localparam int unsigned MA = p_mem_addr_nbits;
  localparam int unsigned MD = p_mem_data_nbits;
  localparam int unsigned PL = MA + MO + 6;
  localparam int unsigned CW = 2*p_net_srcdest_nbits + p_net_opaque_nbits + PL;
  localparam int unsigned RW = MO + MA + MD + 5;
  localparam logic [MA-1:0] SECURE_BASE = MA'(p_secure_base);

  typedef enum logic [1:0] {EMPTY, HAVE_CTRL, HAVE_DATA, JOINED} state_t;

  state_t          state_q,      state_d;
  logic [PL-1:0]   ctrl_slot_q,  ctrl_slot_d;
  logic [MD-1:0]   data_slot_q,  data_slot_d;
  logic            out_val_q,    out_val_d;
  logic            out_deny_q,   out_deny_d;
  logic [RW-1:0]   out_msg_q,    out_msg_d;
  logic [MO-1:0]   out_opaque_q, out_opaque_d;

  logic            ctrl_full, data_full, ctrl_go, data_go;
  logic            ctrl_avail, data_avail, out_drain, out_free, move;
  logic [PL-1:0]   ctrl_cur;
  logic [MD-1:0]   data_cur;
  logic            f_domain;
  logic [2:0]      f_type;
  logic [MO-1:0]   f_opaque;
  logic [MA-1:0]   f_addr;
  logic [1:0]      f_len;
  logic            deny_hit;
  logic            unused_bits;

  // Slot occupancy, handshakes, and the join/move decision; a half arriving
  // this cycle bypasses its slot so a completed join issues next cycle.
  always_comb begin
    ctrl_full    = (state_q == HAVE_CTRL) || (state_q == JOINED);
    data_full    = (state_q == HAVE_DATA) || (state_q == JOINED);
    net_ctrl_rdy = !ctrl_full && !reset;
    net_data_rdy = !data_full && !reset;
    ctrl_go      = net_ctrl_val && net_ctrl_rdy;
    data_go      = net_data_val && net_data_rdy;
    ctrl_avail   = ctrl_full || ctrl_go;
    data_avail   = data_full || data_go;
    ctrl_cur     = ctrl_full ? ctrl_slot_q : net_ctrl_msg[PL-1:0];
    data_cur     = data_full ? data_slot_q : net_data_msg;
    out_drain    = out_val_q && (out_deny_q ? deny_rdy : mem_req_rdy);
    out_free     = !out_val_q || out_drain;
    move         = ctrl_avail && data_avail && out_free;

    f_len    = ctrl_cur[1:0];
    f_addr   = ctrl_cur[MA+1:2];
    f_opaque = ctrl_cur[MA+MO+1:MA+2];
    f_type   = ctrl_cur[MA+MO+4:MA+MO+2];
    f_domain = ctrl_cur[PL-1];

`ifdef PLAB5_MCORE_NET2MEM_DOMAIN_CHECK_EN
    deny_hit = !f_domain && (f_addr >= SECURE_BASE);
`else
    deny_hit = 1'b0;
`endif
  end

  // Next-state and datapath updates for the join FSM and output register.
  always_comb begin
    state_d      = state_q;
    ctrl_slot_d  = ctrl_slot_q;
    data_slot_d  = data_slot_q;
    out_val_d    = out_val_q;
    out_deny_d   = out_deny_q;
    out_msg_d    = out_msg_q;
    out_opaque_d = out_opaque_q;

    if (ctrl_go) ctrl_slot_d = net_ctrl_msg[PL-1:0];
    if (data_go) data_slot_d = net_data_msg;
    if (out_drain) out_val_d = 1'b0;

    if (move) begin
      out_val_d  = 1'b1;
      out_deny_d = deny_hit;
      out_msg_d  = {f_type, f_opaque, f_addr, f_len, data_cur};
      if (deny_hit) out_opaque_d = f_opaque;
    end

    if (move)                         state_d = EMPTY;
    else if (ctrl_avail && data_avail) state_d = JOINED;
    else if (ctrl_avail)              state_d = HAVE_CTRL;
    else if (data_avail)              state_d = HAVE_DATA;
    else                              state_d = EMPTY;
  end

  // State register with synchronous reset; reset drops any held halves and
  // any undelivered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      ctrl_slot_q  <= '0;
      data_slot_q  <= '0;
      out_val_q    <= 1'b0;
      out_deny_q   <= 1'b0;
      out_msg_q    <= '0;
      out_opaque_q <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_slot_q  <= ctrl_slot_d;
      data_slot_q  <= data_slot_d;
      out_val_q    <= out_val_d;
      out_deny_q   <= out_deny_d;
      out_msg_q    <= out_msg_d;
      out_opaque_q <= out_opaque_d;
    end
  end

  assign mem_req_val = out_val_q && !out_deny_q;
  assign deny_val    = out_val_q &&  out_deny_q;
  assign mem_req_msg = out_msg_q;
  assign deny_opaque = out_opaque_q;

  // Network routing fields and the domain bit are intentionally dropped.
  assign unused_bits = ^{net_ctrl_msg[CW-1:PL], f_domain};

endmodule

// File: tb/tb_plab5_mcore_net_to_mem_req_adapter.sv
// Directed self-checking bench for plab5_mcore_net_to_mem_req_adapter.
// Expectations for the deny path follow PLAB5_MCORE_NET2MEM_DOMAIN_CHECK_EN.
module tb_plab5_mcore_net_to_mem_req_adapter;

  logic        clk;
  logic        reset;
  logic        net_ctrl_val, net_ctrl_rdy;
  logic [55:0] net_ctrl_msg;
  logic        net_data_val, net_data_rdy;
  logic [31:0] net_data_msg;
  logic        mem_req_val, mem_req_rdy;
  logic [76:0] mem_req_msg;
  logic        deny_val, deny_rdy;
  logic [7:0]  deny_opaque;

  int compared   = 0;
  int mismatched = 0;

  plab5_mcore_net_to_mem_req_adapter dut (
    .clk          (clk),
    .reset        (reset),
    .net_ctrl_val (net_ctrl_val),
    .net_ctrl_rdy (net_ctrl_rdy),
    .net_ctrl_msg (net_ctrl_msg),
    .net_data_val (net_data_val),
    .net_data_rdy (net_data_rdy),
    .net_data_msg (net_data_msg),
    .mem_req_val  (mem_req_val),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_msg  (mem_req_msg),
    .deny_val     (deny_val),
    .deny_rdy     (deny_rdy),
    .deny_opaque  (deny_opaque)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence below.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [55:0] mk_ctrl(input logic dom, input logic [2:0] typ,
      input logic [7:0] opq, input logic [31:0] addr, input logic [1:0] len);
    return {3'd5, 3'd2, 4'hA, dom, typ, opq, addr, len};
  endfunction

  function automatic logic [76:0] mk_req(input logic [2:0] typ, input logic [7:0] opq,
      input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data);
    return {typ, opq, addr, len, data};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both input halves, then let combinational outputs settle.
  task automatic applyStimulus(input logic cv, input logic [55:0] cm,
                               input logic dv, input logic [31:0] dm);
    net_ctrl_val = cv;
    net_ctrl_msg = cm;
    net_data_val = dv;
    net_data_msg = dm;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic [55:0] c;
  logic [76:0] exp_msg;
  int sent, recv;

  initial begin
    reset = 1'b1;
    mem_req_rdy = 1'b1;
    deny_rdy = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    tick();
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("rst_ctrl_rdy", net_ctrl_rdy, 0);
    checkOutput("rst_data_rdy", net_data_rdy, 0);
    checkOutput("rst_mem_val",  mem_req_val, 0);
    checkOutput("rst_deny_val", deny_val, 0);
    checkOutput("rst_mem_msg",  mem_req_msg, 0);
    checkOutput("rst_deny_opq", deny_opaque, 0);
    reset = 1'b0;
    #1;
    checkOutput("idle_ctrl_rdy", net_ctrl_rdy, 1);
    checkOutput("idle_data_rdy", net_data_rdy, 1);

    // Read with both halves together: issues the following cycle.
    tick();
    applyStimulus(1'b1, mk_ctrl(1'b0, 3'd0, 8'h21, 32'h100, 2'd0), 1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("rd_val", mem_req_val, 1);
    checkOutput("rd_msg", mem_req_msg, mk_req(3'd0, 8'h21, 32'h100, 2'd0, 32'h0));
    checkOutput("rd_deny", deny_val, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("rd_drained", mem_req_val, 0);

    // Control half first, data three cycles later.
    applyStimulus(1'b1, mk_ctrl(1'b1, 3'd1, 8'h33, 32'h200, 2'd0), 1'b0, '0);
    tick();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput("wr_ctrl_rdy_low", net_ctrl_rdy, 0);
      checkOutput("wr_data_rdy_hi", net_data_rdy, 1);
      checkOutput("wr_no_val", mem_req_val, 0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1, 32'hDEADBEEF);
    checkOutput("wr_ctrl_rdy_c5", net_ctrl_rdy, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("wr_val", mem_req_val, 1);
    checkOutput("wr_msg", mem_req_msg, mk_req(3'd1, 8'h33, 32'h200, 2'd0, 32'hDEADBEEF));
    checkOutput("wr_ctrl_rdy_back", net_ctrl_rdy, 1);
    tick();

    // Data half first, then control.
    applyStimulus(1'b0, '0, 1'b1, 32'h12345678);
    tick();
    applyStimulus(1'b1, mk_ctrl(1'b0, 3'd1, 8'h77, 32'h40, 2'd3), 1'b0, '0);
    checkOutput("df_data_rdy_low", net_data_rdy, 0);
    checkOutput("df_ctrl_rdy_hi", net_ctrl_rdy, 1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("df_msg", mem_req_msg, mk_req(3'd1, 8'h77, 32'h40, 2'd3, 32'h12345678));
    checkOutput("df_val", mem_req_val, 1);
    tick();

    // Eight back-to-back requests, memory stalls for three cycles mid-stream.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      mem_req_rdy = !(cyc >= 3 && cyc <= 5);
      c = mk_ctrl(1'b0, 3'd1, 8'h50 + 8'(sent), 32'h1000 + 32'(4*sent), 2'(sent));
      applyStimulus(sent < 8, c, sent < 8, 32'hA000_0000 + 32'(sent));
      checkOutput("bb_no_deny", deny_val, 0);
      if (mem_req_val) begin
        exp_msg = mk_req(3'd1, 8'h50 + 8'(recv), 32'h1000 + 32'(4*recv), 2'(recv),
                         32'hA000_0000 + 32'(recv));
        if (mem_req_rdy) begin
          checkOutput("bb_msg", mem_req_msg, exp_msg);
          recv++;
        end else begin
          checkOutput("bb_hold", mem_req_msg, exp_msg);
        end
      end
      if (net_ctrl_val && net_ctrl_rdy && net_data_rdy) sent++;
      tick();
    end
    mem_req_rdy = 1'b1;
    checkOutput("bb_sent", sent, 8);
    checkOutput("bb_recv", recv, 8);
    checkOutput("bb_idle", mem_req_val, 0);

    // Secure region: domain 0 write to 0x9000, held once with deny_rdy low.
    deny_rdy = 1'b0;
    applyStimulus(1'b1, mk_ctrl(1'b0, 3'd1, 8'h42, 32'h9000, 2'd0), 1'b1, 32'h5555);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
`ifdef PLAB5_MCORE_NET2MEM_DOMAIN_CHECK_EN
    checkOutput("sec_deny_val", deny_val, 1);
    checkOutput("sec_deny_opq", deny_opaque, 8'h42);
    checkOutput("sec_mem_val", mem_req_val, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("sec_deny_hold", deny_opaque, 8'h42);
    checkOutput("sec_deny_val2", deny_val, 1);
    deny_rdy = 1'b1;
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("sec_deny_done", deny_val, 0);
`else
    checkOutput("sec_fwd_val", mem_req_val, 1);
    checkOutput("sec_fwd_msg", mem_req_msg, mk_req(3'd1, 8'h42, 32'h9000, 2'd0, 32'h5555));
    checkOutput("sec_no_deny", deny_val, 0);
    checkOutput("sec_deny_opq0", deny_opaque, 0);
    deny_rdy = 1'b1;
    tick();
`endif
    // Domain 1 to the same address is always forwarded.
    applyStimulus(1'b1, mk_ctrl(1'b1, 3'd1, 8'h43, 32'h9000, 2'd0), 1'b1, 32'h6666);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("dom1_val", mem_req_val, 1);
    checkOutput("dom1_msg", mem_req_msg, mk_req(3'd1, 8'h43, 32'h9000, 2'd0, 32'h6666));
    checkOutput("dom1_deny", deny_val, 0);
    // Boundary: 0x8000 is the first secure address, 0x7FFC the last open one.
    applyStimulus(1'b1, mk_ctrl(1'b0, 3'd0, 8'h44, 32'h8000, 2'd0), 1'b1, 32'h0);
    tick();
    applyStimulus(1'b1, mk_ctrl(1'b0, 3'd0, 8'h45, 32'h7FFC, 2'd0), 1'b1, 32'h0);
`ifdef PLAB5_MCORE_NET2MEM_DOMAIN_CHECK_EN
    checkOutput("bnd_8000_deny", deny_val, 1);
    checkOutput("bnd_8000_mem", mem_req_val, 0);
`else
    checkOutput("bnd_8000_deny", deny_val, 0);
    checkOutput("bnd_8000_mem", mem_req_val, 1);
`endif
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("bnd_7ffc_mem", mem_req_val, 1);
    checkOutput("bnd_7ffc_deny", deny_val, 0);
    checkOutput("bnd_7ffc_msg", mem_req_msg, mk_req(3'd0, 8'h45, 32'h7FFC, 2'd0, 32'h0));
    tick();

    // Reset with a pending output and a captured control half.
    mem_req_rdy = 1'b0;
    applyStimulus(1'b1, mk_ctrl(1'b1, 3'd1, 8'h61, 32'h300, 2'd0), 1'b1, 32'h11);
    tick();
    applyStimulus(1'b1, mk_ctrl(1'b1, 3'd1, 8'h62, 32'h304, 2'd0), 1'b0, '0);
    checkOutput("pre_rst_pending", mem_req_val, 1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("pre_rst_have_ctrl", net_ctrl_rdy, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("post_rst_mem_val", mem_req_val, 0);
    checkOutput("post_rst_deny_val", deny_val, 0);
    checkOutput("post_rst_ctrl_rdy", net_ctrl_rdy, 1);
    checkOutput("post_rst_data_rdy", net_data_rdy, 1);
    mem_req_rdy = 1'b1;
    applyStimulus(1'b1, mk_ctrl(1'b1, 3'd1, 8'h63, 32'h308, 2'd1), 1'b1, 32'h22);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("post_rst_one_val", mem_req_val, 1);
    checkOutput("post_rst_one_msg", mem_req_msg, mk_req(3'd1, 8'h63, 32'h308, 2'd1, 32'h22));
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("post_rst_no_dup", mem_req_val, 0);
    checkOutput("post_rst_no_deny", deny_val, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
